// File: rtl/intrapred_pkg.sv
// rtl/intrapred_pkg.sv - shared state type, MB index width and frame geometry helpers
package intrapred_pkg;

  localparam int MB_IDX_W = 13;

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DONE} mb_state_t;

  function automatic int mbs_per_row(input int width, input int mb_size_w);
    return width / mb_size_w;
  endfunction

  function automatic int num_mb(input int length, input int width,
                                input int mb_size_l, input int mb_size_w);
    return (width / mb_size_w) * (length / mb_size_l);
  endfunction

endpackage

// File: rtl/mb_pos_counter.sv
// rtl/mb_pos_counter.sv - raster column/row position of the current macroblock
module mb_pos_counter
  import intrapred_pkg::*;
#(
  parameter int MBS_PER_ROW = 4,
  parameter int MBS_PER_COL = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                step,
  output logic [MB_IDX_W-1:0] col,
  output logic [MB_IDX_W-1:0] row,
  output logic                last
);

  localparam logic [MB_IDX_W-1:0] COL_MAX = MB_IDX_W'(MBS_PER_ROW - 1);
  localparam logic [MB_IDX_W-1:0] ROW_MAX = MB_IDX_W'(MBS_PER_COL - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= row + MB_IDX_W'(1);
      end else begin
        col <= col + MB_IDX_W'(1);
      end
    end
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/mb_scheduler.sv
// rtl/mb_scheduler.sv - macroblock fetch/handoff scheduler for one frame
// Optional stall counter output enabled by MB_SCHED_STALL_CNT_EN.
module mb_scheduler
  import intrapred_pkg::*;
#(
  parameter int LENGTH      = 64,
  parameter int WIDTH       = 64,
  parameter int MB_SIZE_L   = 16,
  parameter int MB_SIZE_W   = 16,
  parameter int EXTRACT_LAT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                ext_enable,
  output logic [MB_IDX_W-1:0] mbnumber,
  output logic                mb_valid,
  input  logic                mb_ready,
  output logic                mb_first_row,
  output logic                mb_first_col,
  output logic                busy,
  output logic                frame_done
`ifdef MB_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int MBS_PER_ROW = mbs_per_row(WIDTH, MB_SIZE_W);
  localparam int MBS_PER_COL = LENGTH / MB_SIZE_L;
  localparam int NUM_MB      = num_mb(LENGTH, WIDTH, MB_SIZE_L, MB_SIZE_W);
  localparam logic [3:0] LAT_LAST = 4'(EXTRACT_LAT - 1);

  if (NUM_MB > 8192 || MBS_PER_ROW == 0 || MBS_PER_COL == 0 ||
      EXTRACT_LAT < 1 || EXTRACT_LAT > 15) begin : g_bad_cfg
    $error("mb_scheduler: unsupported frame or macroblock geometry");
  end

  mb_state_t                state, state_next;
  logic [3:0]               lat_cnt;
  logic                     clear_pos, step_pos, last;
  logic [MB_IDX_W-1:0]      col, row;

  always_comb begin
    state_next = state;
    ext_enable = 1'b0;
    mb_valid   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: begin
        ext_enable = 1'b1;
        if (lat_cnt == LAT_LAST) state_next = VALID;
      end
      VALID: begin
        mb_valid = 1'b1;
        if (mb_ready) state_next = last ? DONE : FETCH;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Position only moves on an accepted, non-aborted handoff, so abort leaves mbnumber held.
  assign clear_pos = (state == IDLE) && start && !abort;
  assign step_pos  = (state == VALID) && mb_ready && !last && !abort;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lat_cnt  <= 4'd0;
      mbnumber <= '0;
    end else begin
      state    <= state_next;
      lat_cnt  <= (state == FETCH && state_next == FETCH) ? lat_cnt + 4'd1 : 4'd0;
      if (clear_pos)     mbnumber <= '0;
      else if (step_pos) mbnumber <= mbnumber + MB_IDX_W'(1);
    end
  end

  mb_pos_counter #(
    .MBS_PER_ROW(MBS_PER_ROW),
    .MBS_PER_COL(MBS_PER_COL)
  ) u_pos (
    .clk  (clk),
    .reset(reset),
    .clear(clear_pos),
    .step (step_pos),
    .col  (col),
    .row  (row),
    .last (last)
  );

  assign mb_first_row = (row == '0);
  assign mb_first_col = (col == '0);

`ifdef MB_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       stall_cnt <= 16'd0;
    else if (clear_pos)                               stall_cnt <= 16'd0;
    else if (mb_valid && !mb_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mb_scheduler.sv
// tb/tb_mb_scheduler.sv - scoreboard bench for mb_scheduler (default and single-MB builds)
module tb_mb_scheduler;

  localparam int LEN = 64, WID = 64, MBL = 16, MBW = 16, LAT = 3;
  localparam int MPR = WID / MBW;
  localparam int NMB = MPR * (LEN / MBL);

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, mb_ready = 1'b0, s_start = 1'b0;
  logic        ext_enable, mb_valid, mb_first_row, mb_first_col, busy, frame_done;
  logic [12:0] mbnumber;
  logic        s_ext_enable, s_mb_valid, s_mb_first_row, s_mb_first_col, s_busy, s_frame_done;
  logic [12:0] s_mbnumber;
`ifdef MB_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt, s_stall_cnt;
`endif

  always #5 clk = ~clk;

  mb_scheduler #(.LENGTH(LEN), .WIDTH(WID), .MB_SIZE_L(MBL), .MB_SIZE_W(MBW), .EXTRACT_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ext_enable(ext_enable), .mbnumber(mbnumber), .mb_valid(mb_valid), .mb_ready(mb_ready),
    .mb_first_row(mb_first_row), .mb_first_col(mb_first_col), .busy(busy), .frame_done(frame_done)
`ifdef MB_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  mb_scheduler #(.LENGTH(16), .WIDTH(16), .MB_SIZE_L(16), .MB_SIZE_W(16), .EXTRACT_LAT(LAT)) s_dut (
    .clk(clk), .reset(reset), .start(s_start), .abort(abort),
    .ext_enable(s_ext_enable), .mbnumber(s_mbnumber), .mb_valid(s_mb_valid), .mb_ready(mb_ready),
    .mb_first_row(s_mb_first_row), .mb_first_col(s_mb_first_col), .busy(s_busy), .frame_done(s_frame_done)
`ifdef MB_SCHED_STALL_CNT_EN
    , .stall_cnt(s_stall_cnt)
`endif
  );

  typedef struct {
    int num;
    bit first_row;
    bit first_col;
  } mb_exp_t;

  mb_exp_t sb_q[$];
  int      n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: raster order, row = i / per_row, col = i % per_row.
  task automatic push_frame();
    for (int i = 0; i < NMB; i++)
      sb_q.push_back('{num: i, first_row: (i / MPR) == 0, first_col: (i % MPR) == 0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && busy; i++) tick();
    check(name, busy, 0);
  endtask

  task automatic wait_fetch_mb(input int n);
    for (int i = 0; i < 500 && !(ext_enable && mbnumber == 13'(n)); i++) tick();
    check("reach_fetch_mb", {ext_enable, mbnumber}, {1'b1, 13'(n)});
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !mb_valid; i++) tick();
    check("reach_valid", mb_valid, 1);
  endtask

  // Monitor: checks handoffs against the scoreboard plus per-cycle protocol rules.
  int          mcyc = 0, done_due = -1, ext_run = 0;
  bit          prev_valid = 0, expect_idle = 0;
  logic [12:0] prev_mbn = '0, held_mbn = '0;
  mb_exp_t     e;

  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
      ext_run     = 0;
      prev_valid  = 0;
      expect_idle = 0;
      done_due    = -1;
    end else begin
      mcyc++;
      check("busy_vs_outputs", busy, ext_enable | mb_valid | frame_done);
      check("frame_done", frame_done, mcyc == done_due);
      if (expect_idle) begin
        check("abort_idle", {busy, ext_enable, mb_valid}, 0);
        check("abort_mbnumber_held", mbnumber, held_mbn);
        expect_idle = 0;
      end
      if (ext_enable) begin
        if (ext_run > 0) check("fetch_mb_stable", mbnumber, prev_mbn);
        ext_run++;
      end else begin
        if (mb_valid && !prev_valid) check("fetch_len", ext_run, LAT);
        ext_run = 0;
      end
      if (mb_valid && prev_valid) check("valid_mb_stable", mbnumber, prev_mbn);
      if (mb_valid && mb_ready && !abort) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mb: got mbnumber %0d, expected no handoff", mbnumber);
        end else begin
          e = sb_q.pop_front();
          check("mbnumber", mbnumber, e.num);
          check("first_row", mb_first_row, e.first_row);
          check("first_col", mb_first_col, e.first_col);
          if (sb_q.size() == 0) done_due = mcyc + 1;
        end
      end
      if (abort) begin
        sb_q.delete();
        done_due    = -1;
        expect_idle = 1;
        held_mbn    = mbnumber;
      end
      prev_valid = mb_valid;
      prev_mbn   = mbnumber;
    end
  end

  initial begin
    int lat;
    bit seen;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ext_enable", ext_enable, 0);
    check("rst_mbnumber", mbnumber, 0);
    check("rst_mb_valid", mb_valid, 0);
    check("rst_first_row", mb_first_row, 1);
    check("rst_first_col", mb_first_col, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Full frame at full throughput, with start pulses during FETCH and VALID ignored
    mb_ready = 1'b1;
    start_frame();
    lat = 0;
    for (int i = 1; i < 400; i++) begin
      start = (ext_enable && mbnumber == 13'd2) || (mb_valid && mbnumber == 13'd3);
      @(negedge clk);
      if (frame_done) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("frame_latency", lat, NMB * (LAT + 1) + 1);
    tick();
    wait_idle("idle_after_frame");

    // Stall five cycles at mbnumber 5
    start_frame();
    wait_fetch_mb(5);
    mb_ready = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {mb_valid, mbnumber}, {1'b1, 13'd5});
      tick();
    end
    mb_ready = 1'b1;
    wait_idle("idle_after_stall");
`ifdef MB_SCHED_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 5);
`endif

    // Abort in FETCH at mbnumber 7, then restart from 0
    start_frame();
    wait_fetch_mb(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ext_enable", ext_enable, 0);
    check("abort_mbnumber", mbnumber, 7);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    check("abort_no_frame_done", seen, 0);
    tick();
    start_frame();
    check("restart_mbnumber", mbnumber, 0);
    wait_idle("idle_after_restart");

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("start_abort_idle", busy, 0);
      tick();
    end

    // Reset mid-VALID at mbnumber 9
    start_frame();
    wait_fetch_mb(9);
    mb_ready = 1'b0;
    wait_valid();
    #2 reset = 1'b0;
    #1;
    check("arst_ext_enable", ext_enable, 0);
    check("arst_mbnumber", mbnumber, 0);
    check("arst_mb_valid", mb_valid, 0);
    check("arst_first_rc", {mb_first_row, mb_first_col}, 2'b11);
    check("arst_busy", busy, 0);
    check("arst_frame_done", frame_done, 0);
    mb_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    check("post_reset_idle", {busy, mbnumber}, 0);

    // Single-macroblock frame
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat = 0;
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      if (s_mb_valid) check("single_mb", {s_mbnumber, s_mb_first_row, s_mb_first_col}, {13'd0, 2'b11});
      if (s_frame_done) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("single_latency", lat, 5);
    tick();
    check("single_idle", s_busy, 0);

    // Randomized frames with backpressure, ignored starts and occasional abort
    for (int f = 0; f < 8; f++) begin
      mb_ready = 1'b1;
      start_frame();
      for (int i = 0; i < 3000; i++) begin
        mb_ready = ($urandom_range(0, 3) != 0);
        abort    = ($urandom_range(0, 119) == 0);
        start    = (ext_enable || mb_valid) && ($urandom_range(0, 9) == 0);
        tick();
        abort = 1'b0;
        start = 1'b0;
        if (!busy) break;
      end
      check("rand_frame_end", busy, 0);
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
